enigma_stepper: RTL and testbench

- Keystroke controller that sits directly upstream of the rotor/reflector combinational datapath, and captures that datapath's result.
- Holds the three rotor positions and steps them odometer-style on every accepted key, including the Enigma double-step anomaly.
- Presents the key and the post-step positions to the datapath, registers the returned letter, and hands it downstream over a valid/ready handshake.
- Rotor 1 is the fast rotor, i.e. the first rotor the key passes through.

---
 rtl/enigma_stepper.sv | 112 +++++++++++
 tb/tb_enigma_stepper.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/enigma_stepper.sv
// Enigma keystroke controller: holds three rotor positions, steps them odometer-style
// (with the rotor-2 double step) per key, and hands the datapath result downstream.
module enigma_stepper #(
    parameter logic [4:0] NOTCH1 = 5'd16,
    parameter logic [4:0] NOTCH2 = 5'd4,
    parameter logic [4:0] NOTCH3 = 5'd21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [4:0] load_r1,
    input  logic [4:0] load_r2,
    input  logic [4:0] load_r3,
    output logic       load_err,
    input  logic       key_valid,
    input  logic [4:0] key_in,
    output logic       key_ready,
    output logic [4:0] r1,
    output logic [4:0] r2,
    output logic [4:0] r3,
    output logic [4:0] enc_in,
    input  logic [4:0] enc_out,
    output logic       out_valid,
    output logic [4:0] out_char,
    input  logic       out_ready,
    output logic       out_err,
    output logic       notch3_hit
);

    // state | meaning
    // IDLE  | waiting for load or key
    // STEP  | advance rotors from pre-step positions
    // ENC   | datapath settled on new positions; capture result
    // DONE  | result offered downstream until out_ready
    typedef enum logic [1:0] {IDLE, STEP, ENC, DONE} state_t;

    state_t state, state_nxt;
    logic   key_acc;
    logic   key_ok;
    logic   load_ok;

    function automatic logic [4:0] inc26(input logic [4:0] v);
        return (v == 5'd25) ? 5'd0 : v + 5'd1;
    endfunction

    assign key_ok     = (key_in <= 5'd25);
    assign load_ok    = (load_r1 <= 5'd25) && (load_r2 <= 5'd25) && (load_r3 <= 5'd25);
    assign key_acc    = key_valid && key_ready;
    assign out_valid  = (state == DONE);
    assign notch3_hit = (r3 == NOTCH3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        key_ready = 1'b0;
        case (state)
            IDLE: begin
                // load wins over a key offered in the same cycle
                key_ready = !load;
                if (key_acc && key_ok) state_nxt = STEP;
            end
            STEP: state_nxt = ENC;
            ENC:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1       <= 5'd0;
            r2       <= 5'd0;
            r3       <= 5'd0;
            enc_in   <= 5'd0;
            out_char <= 5'd0;
            load_err <= 1'b0;
            out_err  <= 1'b0;
        end else begin
            load_err <= 1'b0;
            out_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        if (load_ok) begin
                            r1 <= load_r1;
                            r2 <= load_r2;
                            r3 <= load_r3;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end else if (key_acc) begin
                        if (key_ok) enc_in  <= key_in;
                        else        out_err <= 1'b1;
                    end
                end
                STEP: begin
                    // all decisions use pre-step positions; r2 at its notch kicks itself too
                    r1 <= inc26(r1);
                    if ((r1 == NOTCH1) || (r2 == NOTCH2)) r2 <= inc26(r2);
                    if (r2 == NOTCH2) r3 <= inc26(r3);
                end
                ENC: out_char <= enc_out;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_enigma_stepper.sv
// Bench for enigma_stepper: a toy datapath function plus a position/latency reference model.
module tb_enigma_stepper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_r1 = '0, load_r2 = '0, load_r3 = '0;
    logic       load_err;
    logic       key_valid = 1'b0;
    logic [4:0] key_in = '0;
    logic       key_ready;
    logic [4:0] r1, r2, r3, enc_in, enc_out, out_char;
    logic       out_valid, out_err, notch3_hit;
    logic       out_ready = 1'b1;

    int total = 0;
    int bad = 0;
    int p1 = 0, p2 = 0, p3 = 0;

    enigma_stepper dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .load_r1(load_r1), .load_r2(load_r2), .load_r3(load_r3), .load_err(load_err),
        .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
        .r1(r1), .r2(r2), .r3(r3), .enc_in(enc_in), .enc_out(enc_out),
        .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready),
        .out_err(out_err), .notch3_hit(notch3_hit)
    );

    always #5 clk = ~clk;

    function automatic int dp(input int k, input int a, input int b, input int c);
        return (k + 3 * a + 7 * b + 11 * c + 5) % 26;
    endfunction

    assign enc_out = 5'(dp(int'(enc_in), int'(r1), int'(r2), int'(r3)));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_pos(input string tag);
        chk({tag, ".r1"}, 32'(r1), 32'(p1));
        chk({tag, ".r2"}, 32'(r2), 32'(p2));
        chk({tag, ".r3"}, 32'(r3), 32'(p3));
        chk({tag, ".n3"}, 32'(notch3_hit), 32'(p3 == 21));
    endtask

    // Rotor motion derived from the mechanical rules, not from the design's registers
    task automatic model_step();
        bit r2_at_notch, r1_at_notch;
        r2_at_notch = (p2 == 4);
        r1_at_notch = (p1 == 16);
        if (r2_at_notch) p3 = (p3 + 1) % 26;
        if (r1_at_notch || r2_at_notch) p2 = (p2 + 1) % 26;
        p1 = (p1 + 1) % 26;
    endtask

    task automatic do_load(input int a, input int b, input int c, input bit with_key);
        bit inv;
        @(negedge clk);
        load = 1'b1;
        load_r1 = 5'(a); load_r2 = 5'(b); load_r3 = 5'(c);
        if (with_key) begin
            key_valid = 1'b1;
            key_in = 5'd3;
            #1 chk("kr_with_load", 32'(key_ready), 32'd0);
        end
        @(negedge clk);
        load = 1'b0;
        key_valid = 1'b0;
        inv = (a > 25) || (b > 25) || (c > 25);
        chk("load_err", 32'(load_err), 32'(inv));
        if (!inv) begin p1 = a; p2 = b; p3 = c; end
        check_pos("load");
        chk("load_ov", 32'(out_valid), 32'd0);
        #1 chk("load_kr", 32'(key_ready), 32'd1);
        @(negedge clk);
        chk("load_err_off", 32'(load_err), 32'd0);
        check_pos("load2");
    endtask

    task automatic send_key(input int k, input int bp);
        int exp;
        @(negedge clk);
        chk("kr_idle", 32'(key_ready), 32'd1);
        key_valid = 1'b1;
        key_in = 5'(k);
        out_ready = (bp == 0);
        @(negedge clk);
        key_valid = 1'b0;
        if (k > 25) begin
            chk("out_err", 32'(out_err), 32'd1);
            chk("drop_ov", 32'(out_valid), 32'd0);
            check_pos("drop");
            @(negedge clk);
            chk("out_err_off", 32'(out_err), 32'd0);
            chk("drop_ov2", 32'(out_valid), 32'd0);
            check_pos("drop2");
        end else begin
            chk("oerr0", 32'(out_err), 32'd0);
            chk("ov_step", 32'(out_valid), 32'd0);
            check_pos("prestep");
            model_step();
            exp = dp(k, p1, p2, p3);
            @(negedge clk);
            check_pos("poststep");
            chk("ov_enc", 32'(out_valid), 32'd0);
            @(negedge clk);
            chk("ov_done", 32'(out_valid), 32'd1);
            chk("out_char", 32'(out_char), 32'(exp));
            chk("kr_done", 32'(key_ready), 32'd0);
            for (int i = 0; i < bp; i++) begin
                if (i == 1) begin key_valid = 1'b1; key_in = 5'd7; end
                @(negedge clk);
                key_valid = 1'b0;
                chk("bp_ov", 32'(out_valid), 32'd1);
                chk("bp_char", 32'(out_char), 32'(exp));
                chk("bp_kr", 32'(key_ready), 32'd0);
                check_pos("bp");
            end
            out_ready = 1'b1;
            @(negedge clk);
            chk("ov_drop", 32'(out_valid), 32'd0);
            chk("kr_back", 32'(key_ready), 32'd1);
            check_pos("after");
        end
    endtask

    // Reset asserted while the key is in ENC (phase 2) or DONE (phase 3)
    task automatic reset_mid(input int phase);
        @(negedge clk);
        key_valid = 1'b1;
        key_in = 5'd9;
        out_ready = 1'b0;
        @(negedge clk);
        key_valid = 1'b0;
        for (int i = 0; i < phase - 1; i++) @(negedge clk);
        if (phase == 3) chk("rst_pre_ov", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        p1 = 0; p2 = 0; p3 = 0;
        check_pos("rst_mid");
        chk("rst_mid_ov", 32'(out_valid), 32'd0);
        chk("rst_mid_char", 32'(out_char), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1 chk("rst_kr", 32'(key_ready), 32'd1);
        @(negedge clk);
        check_pos("rst_after");
        chk("rst_after_ov", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_r1", 32'(r1), 32'd0);
        chk("rst_r2", 32'(r2), 32'd0);
        chk("rst_r3", 32'(r3), 32'd0);
        chk("rst_enc_in", 32'(enc_in), 32'd0);
        chk("rst_char", 32'(out_char), 32'd0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_lerr", 32'(load_err), 32'd0);
        chk("rst_oerr", 32'(out_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_load(0, 0, 0, 1'b0);
        send_key(0, 0);
        do_load(15, 3, 0, 1'b0);
        send_key(1, 0);
        send_key(2, 0);
        send_key(3, 0);
        do_load(25, 25, 25, 1'b0);
        send_key(25, 0);
        do_load(16, 25, 0, 1'b0);
        send_key(4, 0);
        do_load(3, 4, 20, 1'b0);
        send_key(11, 5);
        send_key(26, 0);
        send_key(31, 0);
        do_load(5, 30, 5, 1'b0);
        do_load(6, 7, 8, 1'b1);
        send_key(12, 0);
        do_load(2, 2, 2, 1'b0);
        reset_mid(2);
        do_load(16, 4, 21, 1'b0);
        reset_mid(3);

        for (int n = 0; n < 80; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                do_load($urandom_range(0, 27), $urandom_range(0, 27), $urandom_range(0, 27), 1'b0);
            end else if (r == 2) begin
                do_load($urandom_range(14, 18), $urandom_range(2, 6), $urandom_range(19, 25), 1'b1);
            end else begin
                int k;
                k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(26, 31)) : int'($urandom_range(0, 25));
                send_key(k, $urandom_range(0, 3));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
